// File: rtl/seq_ram_loader_pkg.sv
// Shared widths, depths and the loader state encoding for the ROM-to-RAM sequence copier.
package seq_ram_loader_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ROM_AW  = 10;
    localparam int unsigned RAM_AW  = 7;
    localparam int unsigned SEQ_LEN = 16;
    localparam int unsigned ROM_LAT = 2;
    localparam int unsigned SEL_W   = 6;
    localparam int unsigned SEQ_W   = $clog2(SEQ_LEN);
    localparam int unsigned SLOT_W  = RAM_AW - SEQ_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/seq_ram_loader_if.sv
// Request, ROM read port and RAM write port of the sequence loader bundled as one interface.
interface seq_ram_loader_if;
    import seq_ram_loader_pkg::*;

    logic                load_req;
    logic [SEL_W-1:0]    seq_sel;
    logic [SLOT_W-1:0]   ram_slot;
    logic [ROM_AW-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_q;
    logic [RAM_AW-1:0]   ram_wraddr;
    logic [DATA_W-1:0]   ram_data;
    logic                ram_wren;
    logic                busy;
    logic                done;

    modport master (
        output load_req, seq_sel, ram_slot, rom_q,
        input  rom_addr, ram_wraddr, ram_data, ram_wren, busy, done
    );

    modport slave (
        input  load_req, seq_sel, ram_slot, rom_q,
        output rom_addr, ram_wraddr, ram_data, ram_wren, busy, done
    );

endinterface

// File: rtl/seq_ram_loader_lat_pipe.sv
// Valid delay line matching the ROM read latency; empty flags that no read is still in flight.
module seq_ram_loader_lat_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    output logic vld_out,
    output logic empty
);

    logic [DEPTH-1:0] stg_q;
    logic [DEPTH-1:0] stg_d;

    if (DEPTH == 1) begin : g_one
        always_comb stg_d = vld_in;
    end else begin : g_many
        always_comb stg_d = {stg_q[DEPTH-2:0], vld_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign vld_out = stg_q[DEPTH-1];
    assign empty   = ~|stg_q;

endmodule

// File: rtl/seq_ram_loader.sv
// Copies one SEQ_LEN-word sequence from the ROM read port into a RAM slot on request,
// reporting busy/done so playback never sees a partially written slot.
module seq_ram_loader
    import seq_ram_loader_pkg::*;
(
    input  logic           CLK_50,
    input  logic           reset,
    seq_ram_loader_if.slave bus
);

    loader_state_e       state_q, state_d;
    logic [SEQ_W-1:0]    rd_idx_q, rd_idx_d;
    logic [SEQ_W-1:0]    wr_idx_q, wr_idx_d;
    logic [ROM_AW-1:0]   src_q, src_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [RAM_AW-1:0]   ram_wraddr_q, ram_wraddr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                issue_c;
    logic                pipe_vld;
    logic                pipe_empty;

    seq_ram_loader_lat_pipe #(.DEPTH(ROM_LAT)) u_lat_pipe (
        .clk     (CLK_50),
        .rst     (reset),
        .vld_in  (issue_c),
        .vld_out (pipe_vld),
        .empty   (pipe_empty)
    );

    always_comb begin
        state_d      = state_q;
        rd_idx_d     = rd_idx_q;
        wr_idx_d     = wr_idx_q;
        src_d        = src_q;
        slot_d       = slot_q;
        rom_addr_d   = rom_addr_q;
        ram_wraddr_d = ram_wraddr_q;
        ram_data_d   = ram_data_q;
        ram_wren_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_req) begin
                    state_d    = ST_ISSUE;
                    src_d      = ROM_AW'(32'(bus.seq_sel) << SEQ_W);
                    slot_d     = bus.ram_slot;
                    rom_addr_d = src_d;
                    rd_idx_d   = '0;
                    wr_idx_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_ISSUE: begin
                // The address currently on rom_addr is a real read this cycle.
                issue_c = 1'b1;
                if (rd_idx_q == SEQ_W'(SEQ_LEN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_idx_d   = rd_idx_q + SEQ_W'(1);
                    rom_addr_d = src_q + ROM_AW'(rd_idx_d);
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slot bits on top of the word index keep every write inside the selected slot.
        if (pipe_vld) begin
            ram_wren_d   = 1'b1;
            ram_data_d   = bus.rom_q;
            ram_wraddr_d = {slot_q, wr_idx_q};
            wr_idx_d     = wr_idx_q + SEQ_W'(1);
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_idx_q     <= '0;
            wr_idx_q     <= '0;
            src_q        <= '0;
            slot_q       <= '0;
            rom_addr_q   <= '0;
            ram_wraddr_q <= '0;
            ram_data_q   <= '0;
            ram_wren_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            wr_idx_q     <= wr_idx_d;
            src_q        <= src_d;
            slot_q       <= slot_d;
            rom_addr_q   <= rom_addr_d;
            ram_wraddr_q <= ram_wraddr_d;
            ram_data_q   <= ram_data_d;
            ram_wren_q   <= ram_wren_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.ram_wraddr = ram_wraddr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
